// File: rtl/memory_bus_pkg.sv
// Shared MemoryBus field widths and the request record carried through the
// bus_read_tagger request buffer.
package memory_bus_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 24;
   localparam int ID_W   = 8;

   typedef struct packed {
      logic              write;
      logic [ADDR_W-1:0] address;
      logic [DATA_W-1:0] data;
      logic [ID_W-1:0]   id;
   } bus_req_t;

   localparam int REQ_W = $bits(bus_req_t);

   function automatic logic is_read(input bus_req_t req);
      return !req.write;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered head, occupancy count and async reset.
// DEPTH must be at least 2; pointers wrap explicitly so any DEPTH works.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_W'(DEPTH-1)) ? '0 : ptr + PTR_W'(1);
   endfunction

   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign pop_data = mem_q[rd_ptr_q];
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;

   // NOTE: every variable gets its default before any branch, so no latch is inferred.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
   end

   // NOTE: state updates use non-blocking assignments so all flops sample together.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; empty/count guard every read of it.
   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/bus_read_tagger.sv
// Buffers MemoryBus requests toward the AXI4-Lite bridge, queues the ID of each
// issued read, and stamps in-order read responses with the queued ID.
module bus_read_tagger
   import memory_bus_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int REQ_SLOTS = 2
) (
   input  logic                       clock,
   input  logic                       reset,
   // upstream (from master)
   input  logic                       up_ms_valid,
   output logic                       up_ms_taken,
   input  logic                       up_ms_write,
   input  logic [ADDR_W-1:0]          up_ms_address,
   input  logic [DATA_W-1:0]          up_ms_data,
   input  logic [ID_W-1:0]            up_ms_id,
   output logic                       up_sm_valid,
   input  logic                       up_sm_taken,
   output logic [DATA_W-1:0]          up_sm_data,
   output logic [ID_W-1:0]            up_sm_id,
   // downstream (to bridge)
   output logic                       down_ms_valid,
   input  logic                       down_ms_taken,
   output logic                       down_ms_write,
   output logic [ADDR_W-1:0]          down_ms_address,
   output logic [DATA_W-1:0]          down_ms_data,
   output logic [ID_W-1:0]            down_ms_id,
   input  logic                       down_sm_valid,
   output logic                       down_sm_taken,
   input  logic [DATA_W-1:0]          down_sm_data,
   input  logic [ID_W-1:0]            down_sm_id,
   // status
   output logic [$clog2(DEPTH+1)-1:0] outstanding,
   output logic                       orphan_err
);

   localparam int OUT_W = $clog2(DEPTH+1);

   bus_req_t                         req_in;
   bus_req_t                         req_head;
   logic                             req_full, req_empty, req_push, req_pop;
   logic [$clog2(REQ_SLOTS+1)-1:0]   unused_req_count;

   logic [ID_W-1:0]                  tag_head;
   logic                             tag_full, tag_empty, tag_push, tag_pop;
   logic [OUT_W-1:0]                 unused_tag_count;
   logic                             unused_sm_id;

   logic [OUT_W-1:0]                 outstanding_q, outstanding_d;
   logic                             orphan_err_q, orphan_err_d;
   logic                             head_is_read;

   assign req_in = '{write: up_ms_write, address: up_ms_address,
                     data: up_ms_data, id: up_ms_id};

   // Acceptance is masked during reset so no beat is taken while the buffer is cleared.
   assign up_ms_taken = up_ms_valid && !req_full && !reset;
   assign req_push    = up_ms_taken;

   // A read at the head waits for a free tag slot, even if one frees this cycle,
   // which keeps smTaken out of the msValid cone.
   assign head_is_read  = is_read(req_head);
   assign down_ms_valid = !req_empty && !(head_is_read && tag_full);
   assign req_pop       = down_ms_valid && down_ms_taken;
   assign tag_push      = req_pop && head_is_read;

   assign down_ms_write   = req_head.write;
   assign down_ms_address = req_head.address;
   assign down_ms_data    = req_head.data;
   assign down_ms_id      = req_head.id;

   assign up_sm_valid   = down_sm_valid && !reset;
   assign down_sm_taken = up_sm_taken && !reset;
   assign up_sm_data    = down_sm_data;
   assign up_sm_id      = tag_empty ? '0 : tag_head;
   assign tag_pop       = down_sm_valid && down_sm_taken && !tag_empty;

   // The bridge's response ID carries no information; the tag FIFO replaces it.
   assign unused_sm_id  = ^down_sm_id;

   assign outstanding = outstanding_q;
   assign orphan_err  = orphan_err_q;

   sync_fifo #(
      .WIDTH (REQ_W),
      .DEPTH (REQ_SLOTS)
   ) u_req_buf (
      .clock     (clock),
      .reset     (reset),
      .push      (req_push),
      .push_data (req_in),
      .pop       (req_pop),
      .pop_data  (req_head),
      .full      (req_full),
      .empty     (req_empty),
      .count     (unused_req_count)
   );

   sync_fifo #(
      .WIDTH (ID_W),
      .DEPTH (DEPTH)
   ) u_tag_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (tag_push),
      .push_data (req_head.id),
      .pop       (tag_pop),
      .pop_data  (tag_head),
      .full      (tag_full),
      .empty     (tag_empty),
      .count     (unused_tag_count)
   );

   always_comb begin
      outstanding_d = outstanding_q;
      orphan_err_d  = orphan_err_q;
      case ({tag_push, tag_pop})
         2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
         2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
         default: outstanding_d = outstanding_q;
      endcase
      if (down_sm_valid && tag_empty) orphan_err_d = 1'b1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         outstanding_q <= '0;
         orphan_err_q  <= 1'b0;
      end else begin
         outstanding_q <= outstanding_d;
         orphan_err_q  <= orphan_err_d;
      end
   end

endmodule

// File: tb/tb_bus_read_tagger.sv
// Directed bench for bus_read_tagger: request ordering, tag stamping, full-FIFO
// stall, same-cycle push/pop, orphan responses and reset mid-operation.
module tb_bus_read_tagger;
   import memory_bus_pkg::*;

   localparam int DEPTH     = 4;
   localparam int REQ_SLOTS = 2;
   localparam int OUT_W     = $clog2(DEPTH+1);

   logic              clock = 1'b0;
   logic              reset;
   logic              up_ms_valid, up_ms_taken, up_ms_write;
   logic [ADDR_W-1:0] up_ms_address;
   logic [DATA_W-1:0] up_ms_data;
   logic [ID_W-1:0]   up_ms_id;
   logic              up_sm_valid, up_sm_taken;
   logic [DATA_W-1:0] up_sm_data;
   logic [ID_W-1:0]   up_sm_id;
   logic              down_ms_valid, down_ms_taken, down_ms_write;
   logic [ADDR_W-1:0] down_ms_address;
   logic [DATA_W-1:0] down_ms_data;
   logic [ID_W-1:0]   down_ms_id;
   logic              down_sm_valid, down_sm_taken;
   logic [DATA_W-1:0] down_sm_data;
   logic [ID_W-1:0]   down_sm_id;
   logic [OUT_W-1:0]  outstanding;
   logic              orphan_err;

   always #5 clock = ~clock;

   bus_read_tagger #(
      .DEPTH     (DEPTH),
      .REQ_SLOTS (REQ_SLOTS)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .up_ms_valid     (up_ms_valid),
      .up_ms_taken     (up_ms_taken),
      .up_ms_write     (up_ms_write),
      .up_ms_address   (up_ms_address),
      .up_ms_data      (up_ms_data),
      .up_ms_id        (up_ms_id),
      .up_sm_valid     (up_sm_valid),
      .up_sm_taken     (up_sm_taken),
      .up_sm_data      (up_sm_data),
      .up_sm_id        (up_sm_id),
      .down_ms_valid   (down_ms_valid),
      .down_ms_taken   (down_ms_taken),
      .down_ms_write   (down_ms_write),
      .down_ms_address (down_ms_address),
      .down_ms_data    (down_ms_data),
      .down_ms_id      (down_ms_id),
      .down_sm_valid   (down_sm_valid),
      .down_sm_taken   (down_sm_taken),
      .down_sm_data    (down_sm_data),
      .down_sm_id      (down_sm_id),
      .outstanding     (outstanding),
      .orphan_err      (orphan_err)
   );

   typedef struct {
      logic        write;
      logic [31:0] addr;
      logic [23:0] data;
      logic [7:0]  id;
      logic [23:0] rdata;
      logic [7:0]  exp_tag;
   } vec_t;

   vec_t vecs [10];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic idle();
      up_ms_valid   = 1'b0;
      up_ms_write   = 1'b0;
      up_ms_address = '0;
      up_ms_data    = '0;
      up_ms_id      = '0;
      up_sm_taken   = 1'b0;
      down_ms_taken = 1'b0;
      down_sm_valid = 1'b0;
      down_sm_data  = '0;
      down_sm_id    = '0;
   endtask

   task automatic drive_req(input logic wr, input logic [31:0] addr, input logic [23:0] data,
                            input logic [7:0] id);
      up_ms_valid   = 1'b1;
      up_ms_write   = wr;
      up_ms_address = addr;
      up_ms_data    = data;
      up_ms_id      = id;
   endtask

   // One response beat from the bridge, accepted upstream the same cycle.
   task automatic respond(input string name, input logic [23:0] rdata, input logic [7:0] raw_id,
                          input logic [7:0] exp_id);
      @(negedge clock);
      down_sm_valid = 1'b1;
      down_sm_data  = rdata;
      down_sm_id    = raw_id;
      up_sm_taken   = 1'b1;
      #1;
      check({name, " up_sm_valid"}, up_sm_valid, 1);
      check({name, " up_sm_id"}, up_sm_id, exp_id);
      check({name, " up_sm_data"}, up_sm_data, rdata);
      check({name, " down_sm_taken"}, down_sm_taken, 1);
      @(negedge clock);
      down_sm_valid = 1'b0;
      up_sm_taken   = 1'b0;
      down_sm_id    = '0;
   endtask

   // Feeds vecs[first +: n] upstream and checks each beat downstream, in order,
   // every cycle it is presented (so stalled beats must hold their fields).
   task automatic stream(input string name, input int first, input int n, input bit toggle);
      int in_idx  = first;
      int mon_idx = first;
      int cyc     = 0;
      while (mon_idx < first + n && cyc < 40) begin
         @(negedge clock);
         if (in_idx < first + n)
            drive_req(vecs[in_idx].write, vecs[in_idx].addr, vecs[in_idx].data, vecs[in_idx].id);
         else
            up_ms_valid = 1'b0;
         down_ms_taken = toggle ? (cyc % 2 == 0) : 1'b1;
         #1;
         if (down_ms_valid) begin
            check({name, " down_ms_write"}, down_ms_write, vecs[mon_idx].write);
            check({name, " down_ms_address"}, down_ms_address, vecs[mon_idx].addr);
            check({name, " down_ms_data"}, down_ms_data, vecs[mon_idx].data);
            check({name, " down_ms_id"}, down_ms_id, vecs[mon_idx].id);
            if (down_ms_taken) mon_idx++;
         end
         if (up_ms_valid && up_ms_taken) in_idx++;
         cyc++;
      end
      check({name, " beats issued"}, 64'(mon_idx), 64'(first + n));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      //              write  addr        data       id     rdata      exp_tag
      vecs[0] = '{1'b1, 32'h100, 24'h111111, 8'h31, 24'h000000, 8'h00};
      vecs[1] = '{1'b0, 32'h104, 24'h000000, 8'h09, 24'h909090, 8'h09};
      vecs[2] = '{1'b1, 32'h108, 24'h222222, 8'h32, 24'h000000, 8'h00};
      vecs[3] = '{1'b0, 32'h10C, 24'h000000, 8'h0A, 24'hA0A0A0, 8'h0A};
      vecs[4] = '{1'b0, 32'h200, 24'h000000, 8'h21, 24'h002121, 8'h21};
      vecs[5] = '{1'b0, 32'h204, 24'h000000, 8'h22, 24'h002222, 8'h22};
      vecs[6] = '{1'b0, 32'h300, 24'h000000, 8'h61, 24'h006161, 8'h61};
      vecs[7] = '{1'b0, 32'h304, 24'h000000, 8'h62, 24'h006262, 8'h62};
      vecs[8] = '{1'b0, 32'h308, 24'h000000, 8'h63, 24'h006363, 8'h63};
      vecs[9] = '{1'b0, 32'h400, 24'h000000, 8'h07, 24'h070707, 8'h07};

      // Reset values, with a request already offered.
      idle();
      reset = 1'b1;
      up_ms_valid = 1'b1;
      @(negedge clock);
      #1;
      check("reset up_ms_taken", up_ms_taken, 0);
      check("reset down_ms_valid", down_ms_valid, 0);
      check("reset up_sm_valid", up_sm_valid, 0);
      check("reset outstanding", outstanding, 0);
      check("reset orphan_err", orphan_err, 0);
      @(negedge clock);
      reset = 1'b0;
      idle();

      // 1: single read, tag replaces the bridge's ID.
      @(negedge clock);
      drive_req(1'b0, 32'h10, 24'h0, 8'h5A);
      down_ms_taken = 1'b1;
      #1;
      check("t1 accept", up_ms_taken, 1);
      @(negedge clock);
      up_ms_valid = 1'b0;
      #1;
      check("t1 down_ms_valid", down_ms_valid, 1);
      check("t1 down_ms_id", down_ms_id, 8'h5A);
      check("t1 down_ms_address", down_ms_address, 32'h10);
      check("t1 down_ms_write", down_ms_write, 0);
      @(negedge clock);
      #1;
      check("t1 idle after issue", down_ms_valid, 0);
      check("t1 outstanding", outstanding, 1);
      respond("t1 resp", 24'hABCDEF, 8'h00, 8'h5A);
      check("t1 outstanding after", outstanding, 0);
      check("t1 orphan_err", orphan_err, 0);

      // 2: fill the tag FIFO, fifth read stalls until one response returns.
      idle();
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         drive_req(1'b0, 32'h500 + 32'(i), 24'h0, 8'(i + 1));
         down_ms_taken = 1'b1;
         #1;
         check("t2 accept", up_ms_taken, 1);
         if (i > 0) begin
            check("t2 issue valid", down_ms_valid, 1);
            check("t2 issue id", down_ms_id, 8'(i));
         end
      end
      @(negedge clock);
      up_ms_valid = 1'b0;
      #1;
      check("t2 stall at full", down_ms_valid, 0);
      check("t2 outstanding full", outstanding, 4);
      @(negedge clock);
      down_sm_valid = 1'b1;
      down_sm_data  = 24'h000101;
      down_sm_id    = 8'hEE;
      up_sm_taken   = 1'b1;
      #1;
      check("t2 first resp id", up_sm_id, 8'h01);
      check("t2 no issue while popping at full", down_ms_valid, 0);
      @(negedge clock);
      down_sm_valid = 1'b0;
      up_sm_taken   = 1'b0;
      #1;
      check("t2 outstanding after pop", outstanding, 3);
      check("t2 id5 valid", down_ms_valid, 1);
      check("t2 id5 id", down_ms_id, 8'h05);
      @(negedge clock);
      #1;
      check("t2 outstanding refilled", outstanding, 4);
      check("t2 buffer drained", down_ms_valid, 0);
      for (int i = 2; i <= 5; i++)
         respond("t2 resp", 24'(i * 24'h010101), 8'hEE, 8'(i));
      check("t2 outstanding drained", outstanding, 0);

      // 3: mixed writes and reads with a toggling downstream ready.
      idle();
      stream("t3", 0, 4, 1'b1);
      @(negedge clock);
      down_ms_taken = 1'b0;
      #1;
      check("t3 only reads tagged", outstanding, 2);
      for (int i = 0; i < 4; i++)
         if (!vecs[i].write) respond("t3 resp", vecs[i].rdata, 8'hEE, vecs[i].exp_tag);
      check("t3 outstanding after", outstanding, 0);

      // 4: push and pop on the same edge with two reads outstanding.
      idle();
      stream("t4", 4, 2, 1'b0);
      @(negedge clock);
      drive_req(1'b0, 32'h208, 24'h0, 8'h23);
      down_ms_taken = 1'b1;
      #1;
      check("t4 accept", up_ms_taken, 1);
      check("t4 outstanding before", outstanding, 2);
      @(negedge clock);
      up_ms_valid   = 1'b0;
      down_sm_valid = 1'b1;
      down_sm_data  = vecs[4].rdata;
      down_sm_id    = 8'hEE;
      up_sm_taken   = 1'b1;
      #1;
      check("t4 issue alongside pop", down_ms_valid, 1);
      check("t4 issue id", down_ms_id, 8'h23);
      check("t4 resp id", up_sm_id, vecs[4].exp_tag);
      @(negedge clock);
      down_sm_valid = 1'b0;
      up_sm_taken   = 1'b0;
      #1;
      check("t4 outstanding unchanged", outstanding, 2);
      respond("t4 resp", vecs[5].rdata, 8'hEE, vecs[5].exp_tag);
      respond("t4 resp", 24'h002323, 8'hEE, 8'h23);
      check("t4 outstanding after", outstanding, 0);

      // 5: response with nothing outstanding.
      idle();
      check("t5 orphan_err before", orphan_err, 0);
      respond("t5 orphan", 24'h0BAD00, 8'hEE, 8'h00);
      check("t5 orphan_err set", orphan_err, 1);
      check("t5 no underflow", outstanding, 0);
      repeat (3) @(negedge clock);
      check("t5 orphan_err held", orphan_err, 1);

      // 6: reset with three reads outstanding and one buffered.
      idle();
      stream("t6", 6, 3, 1'b0);
      @(negedge clock);
      drive_req(1'b0, 32'h30C, 24'h0, 8'h64);
      down_ms_taken = 1'b0;
      #1;
      check("t6 accept buffered", up_ms_taken, 1);
      @(negedge clock);
      up_ms_valid = 1'b0;
      #1;
      check("t6 buffered valid", down_ms_valid, 1);
      check("t6 outstanding before reset", outstanding, 3);
      #2;
      up_ms_valid   = 1'b1;
      down_sm_valid = 1'b1;
      reset         = 1'b1;
      #1;
      check("t6 reset down_ms_valid", down_ms_valid, 0);
      check("t6 reset outstanding", outstanding, 0);
      check("t6 reset orphan_err", orphan_err, 0);
      check("t6 reset up_ms_taken", up_ms_taken, 0);
      check("t6 reset up_sm_valid", up_sm_valid, 0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      idle();
      for (int i = 6; i < 9; i++)
         respond("t6 stale", vecs[i].rdata, 8'hEE, 8'h00);
      check("t6 stale orphan_err", orphan_err, 1);
      check("t6 stale outstanding", outstanding, 0);
      stream("t6 new", 9, 1, 1'b0);
      @(negedge clock);
      down_ms_taken = 1'b0;
      #1;
      check("t6 new outstanding", outstanding, 1);
      respond("t6 new resp", vecs[9].rdata, 8'hEE, vecs[9].exp_tag);
      check("t6 outstanding after", outstanding, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
